// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master side issues requests; the slave side is the subtractor.
interface serial_subtractor_if #(
  parameter int unsigned W = 4
);
  logic         start;
  logic [W-1:0] input_A;
  logic [W-1:0] input_B;
  logic         borrow_in;
  logic         busy;
  logic         done;
  logic [W-1:0] output_D;
  logic         borrow_Out;

  modport master (
    output start, input_A, input_B, borrow_in,
    input  busy, done, output_D, borrow_Out
  );

  modport slave (
    input  start, input_A, input_B, borrow_in,
    output busy, done, output_D, borrow_Out
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor: one full-subtractor cell, LSB first, W cycles
// per operation, start/busy/done handshake; result held until the next completion.
module serial_subtractor #(
  parameter int unsigned W = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  serial_subtractor_if.slave  bus
);
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t        state;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  r_sh;
  logic [CW-1:0] cnt;
  logic          br;
  logic          busy_r;
  logic          done_r;
  logic [W-1:0]  d_r;
  logic          bo_r;

  logic          a;
  logic          b;
  logic          d;
  logic          bo;
  logic [W-1:0]  r_next;

  always_comb begin
    a      = a_sh[0];
    b      = b_sh[0];
    d      = a ^ b ^ br;
    bo     = (~a & b) | (~(a ^ b) & br);
    // Difference bits enter from the MSB side so bit i lands in place after W shifts.
    r_next = {d, r_sh[W-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      d_r    <= '0;
      bo_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_sh   <= bus.input_A;
            b_sh   <= bus.input_B;
            br     <= bus.borrow_in;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= r_next;
          br   <= bo;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) begin
            d_r    <= r_next;
            bo_r   <= bo;
            done_r <= 1'b1;
            busy_r <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.output_D   = d_r;
  assign bus.borrow_Out = bo_r;
endmodule
